arbitre_piles: RTL and testbench
================================

# arbitre_piles

Scheduler sharing a bank of `NCOL` brick-column height counters between two requesters: the player-drop path (add a brick) and the clear/gravity path (remove a brick). It grants one request at a time, drives one-cycle `Plus`/`Moins` pulses to the selected column counter with the mandatory low gap the counter's press detector needs, refuses overflow and underflow, and returns a one-cycle acknowledge. It sits between the game-logic requesters and the column counters.

## Interface
- `NCOL`, 4: number of columns; `NCOL` ≥ 2, with `CW = $clog2(NCOL)`.
- `HMAX`, 7: maximum height; must be ≤ 7 because counters are 3 bits.
- `clk` in 1: single clock; everything is posedge.
- `reset` in 1: synchronous, active-high.
- `drop_req` in 1: level request to add a brick; held until `drop_ack`.
- `drop_col` in CW: target column for drop.
- `clear_req` in 1: level request to remove a brick; held until `clear_ack`.
- `clear_col` in CW: target column for clear.
- `hauteurs` in 3*NCOL: column heights; column k is at `[3k+2:3k]`.
- `plus` out NCOL: one-hot increment pulse to the column counters.
- `moins` out NCOL: one-hot decrement pulse to the column counters.
- `drop_ack` out 1: one-cycle pulse that ends a drop transaction.
- `clear_ack` out 1: one-cycle pulse that ends a clear transaction.
- `rej` out 1: valid with an ack; high means the request was refused and nothing changed.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, GAP and ACK. All outputs are registered.
- In IDLE, if either request is high, the controller picks a winner (see Configuration). It latches the winner's type and column, and samples that column's height from `hauteurs`.
- Drop with latched height ≥ `HMAX`:
  - Go to ACK with `rej`=1.
  - Never pulse `plus`.
- Clear with latched height = 0:
  - Go to ACK with `rej`=1.
  - Never pulse `moins`.
- Otherwise go to ISSUE.
- ISSUE:
  - Drive `plus[col]`=1 for a drop, or `moins[col]`=1 for a clear.
  - Assert exactly one bit, for exactly one cycle.
  - Go to GAP.
- GAP:
  - `plus` and `moins` are all 0. This lets the counter's pressed flag clear before the next pulse.
  - Go to ACK.
- ACK:
  - Assert the winner's ack with `rej` as decided, for one cycle.
  - Go to IDLE.
- Changes on `*_col` or `hauteurs` after the latch are ignored for the current transaction.
- A non-winning request stays pending and is evaluated again in the next IDLE cycle. It is never lost.
- Both columns being equal is irrelevant: the two request types are handled independently.
- `reset` from any state:
  - Next state is IDLE.
  - `plus`, `moins`, both acks, `rej` and `busy` are all 0.
  - An in-flight transaction is abandoned with no ack.
  - The round-robin pointer returns to "clear first".
- Reset value of every output is 0.

## Timing
- Request high in IDLE during cycle t, accepted:
  - Cycle t+1: ISSUE, pulse high.
  - Cycle t+2: GAP.
  - Cycle t+3: ACK.
  - Cycle t+4: IDLE.
- The counter updates at the end of cycle t+1, so the new height is visible at t+2, before the ack.
- Refused request: ack and `rej` in cycle t+1, IDLE in cycle t+2.
- `busy` rises in cycle t+1 and falls in the IDLE cycle after ACK.
- Requester rule: deassert `req` in the cycle after ack. If `req` is still high in that IDLE cycle, it is treated as a new request.
- Any two pulses to the same column are separated by at least 3 low cycles. Throughput is therefore one accepted operation per 4 cycles.

## Configuration
- `ARB_RR_EN` defined:
  - Round-robin between the two request types on conflicts. A 1-bit pointer favours the type not granted last.
  - The pointer toggles only when both were pending at the grant.
  - The pointer resets to favour clear.
- `ARB_RR_EN` undefined:
  - Fixed priority: clear always wins over drop.
  - Drop may starve while `clear_req` stays high.

## Test plan
- Drop, column 2 at height 3, during cycle t:
  - `plus`=4'b0100 in t+1 only.
  - `drop_ack`=1 and `rej`=0 in t+3.
  - Column 2 reads 4 from t+2.
- Drop, column 1 at height 7:
  - `drop_ack`=1 and `rej`=1 in t+1.
  - `plus` stays 0.
  - Height stays 7.
- Clear, column 0 at height 0:
  - `clear_ack`=1 and `rej`=1 in t+1.
  - `moins` stays 0.
- `drop_req` and `clear_req` held together, columns 3 and 3 at height 2:
  - With `ARB_RR_EN`: clear acks first, then drop. Final height 2.
  - Without it: clear wins every grant until `clear_req` drops. Height goes 2, 1, 0, then `rej`.
- `reset` asserted during GAP of a drop on column 1 (height 4→5):
  - Next cycle all outputs are 0.
  - No ack is issued.
  - The counter has incremented exactly once.
- Back-to-back drops on column 3 starting at height 5:
  - Heights become 6 then 7. The third drop gets `rej`=1.
  - At least 3 zero cycles separate the `plus[3]` pulses.

Source files
------------

// File: rtl/arbitre_piles.sv
// -----------------------------------------------------------------------------
// arbitre_piles
//
// Shares a bank of NCOL brick-column height counters between two requesters:
// the player-drop path (adds a brick) and the clear/gravity path (removes a
// brick). One request is granted at a time. An accepted request produces a
// single one-cycle plus/moins pulse followed by a mandatory low gap cycle and
// then a one-cycle acknowledge. Requests that would overflow (height >= HMAX)
// or underflow (height == 0) are acknowledged immediately with rej=1.
//
// Optional feature macro: ARB_RR_EN
//   defined   : round-robin between drop and clear on conflicts
//   undefined : fixed priority, clear always wins over drop
//
// Parameters
//   NCOL : number of columns (>= 2)
//   HMAX : maximum column height (<= 7, counters are 3 bits)
//
// Ports
//   clk       : clock, everything on posedge
//   reset     : synchronous active-high reset
//   drop_req  : level request to add a brick, held until drop_ack
//   drop_col  : target column of the drop
//   clear_req : level request to remove a brick, held until clear_ack
//   clear_col : target column of the clear
//   hauteurs  : column heights, column k at [3k+2:3k]
//   plus      : one-hot increment pulse to the column counters
//   moins     : one-hot decrement pulse to the column counters
//   drop_ack  : one-cycle end of a drop transaction
//   clear_ack : one-cycle end of a clear transaction
//   rej       : valid with an ack, high when the request was refused
//   busy      : high whenever the controller is not idle
// -----------------------------------------------------------------------------
module arbitre_piles #(
  parameter int NCOL = 4,
  parameter int HMAX = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    drop_req,
  input  logic [$clog2(NCOL)-1:0] drop_col,
  input  logic                    clear_req,
  input  logic [$clog2(NCOL)-1:0] clear_col,
  input  logic [3*NCOL-1:0]       hauteurs,
  output logic [NCOL-1:0]         plus,
  output logic [NCOL-1:0]         moins,
  output logic                    drop_ack,
  output logic                    clear_ack,
  output logic                    rej,
  output logic                    busy
);

  localparam int         CW     = $clog2(NCOL);
  localparam logic [2:0] HMAX_H = 3'(HMAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_ACK
  } state_e;

  // Transaction state
  state_e          state_q,    state_d;
  logic            is_clear_q, is_clear_d;
  logic [CW-1:0]   col_q,      col_d;
  logic            refuse_q,   refuse_d;

`ifdef ARB_RR_EN
  // 1 = drop is favoured on the next conflict, 0 = clear is favoured
  logic            rr_q,       rr_d;
`endif

  // Registered outputs
  logic [NCOL-1:0] plus_q,      plus_d;
  logic [NCOL-1:0] moins_q,     moins_d;
  logic            drop_ack_q,  drop_ack_d;
  logic            clear_ack_q, clear_ack_d;
  logic            rej_q,       rej_d;
  logic            busy_q,      busy_d;

  // Arbitration helpers
  logic [2:0]      h_arr [NCOL];
  logic            grant_clear;
  logic [CW-1:0]   sel_col;
  logic [2:0]      sel_h;
  logic [NCOL-1:0] col_onehot;

  always_comb begin
    for (int unsigned k = 0; k < NCOL; k++) begin
      h_arr[k] = hauteurs[3*k +: 3];
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      is_clear_q  <= 1'b0;
      col_q       <= '0;
      refuse_q    <= 1'b0;
`ifdef ARB_RR_EN
      rr_q        <= 1'b0;
`endif
      plus_q      <= '0;
      moins_q     <= '0;
      drop_ack_q  <= 1'b0;
      clear_ack_q <= 1'b0;
      rej_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_clear_q  <= is_clear_d;
      col_q       <= col_d;
      refuse_q    <= refuse_d;
`ifdef ARB_RR_EN
      rr_q        <= rr_d;
`endif
      plus_q      <= plus_d;
      moins_q     <= moins_d;
      drop_ack_q  <= drop_ack_d;
      clear_ack_q <= clear_ack_d;
      rej_q       <= rej_d;
      busy_q      <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: arbitration, latching and overflow/underflow decision
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    is_clear_d = is_clear_q;
    col_d      = col_q;
    refuse_d   = refuse_q;
`ifdef ARB_RR_EN
    rr_d       = rr_q;
    // Clear wins unless drop is also pending and currently favoured
    grant_clear = clear_req && !(drop_req && rr_q);
`else
    grant_clear = clear_req;
`endif
    sel_col = grant_clear ? clear_col : drop_col;
    sel_h   = h_arr[sel_col];

    case (state_q)
      S_IDLE: begin
        if (drop_req || clear_req) begin
          is_clear_d = grant_clear;
          col_d      = sel_col;
          refuse_d   = grant_clear ? (sel_h == 3'd0) : (sel_h >= HMAX_H);
          state_d    = refuse_d ? S_ACK : S_ISSUE;
`ifdef ARB_RR_EN
          // Pointer only moves on a real conflict, towards the loser
          if (drop_req && clear_req) begin
            rr_d = grant_clear;
          end
`endif
        end
      end
      S_ISSUE: state_d = S_GAP;
      S_GAP:   state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the upcoming state so every output is a flop
  // ---------------------------------------------------------------------------
  always_comb begin
    plus_d      = '0;
    moins_d     = '0;
    drop_ack_d  = 1'b0;
    clear_ack_d = 1'b0;
    rej_d       = 1'b0;
    busy_d      = (state_d != S_IDLE);
    col_onehot  = {{(NCOL-1){1'b0}}, 1'b1} << col_d;

    case (state_d)
      S_ISSUE: begin
        if (is_clear_d) begin
          moins_d = col_onehot;
        end else begin
          plus_d  = col_onehot;
        end
      end
      S_ACK: begin
        clear_ack_d = is_clear_d;
        drop_ack_d  = !is_clear_d;
        rej_d       = refuse_d;
      end
      default: ;
    endcase
  end

  assign plus      = plus_q;
  assign moins     = moins_q;
  assign drop_ack  = drop_ack_q;
  assign clear_ack = clear_ack_q;
  assign rej       = rej_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_arbitre_piles.sv
// -----------------------------------------------------------------------------
// tb_arbitre_piles
//
// Bench for arbitre_piles. The column counters are emulated in the bench and
// fed back on hauteurs. A transaction-level model turns each grant into the
// list of output values expected over the following cycles; every cycle the
// DUT outputs are compared against it. Directed scenarios add literal
// expectations, then a randomized phase exercises arbitration, refusals,
// counter reloads and resets.
// -----------------------------------------------------------------------------
module tb_arbitre_piles;

  localparam int NCOL = 4;
  localparam int HMAX = 7;
  localparam int CW   = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 drop_req;
  logic [CW-1:0]        drop_col;
  logic                 clear_req;
  logic [CW-1:0]        clear_col;
  logic [3*NCOL-1:0]    hauteurs;
  logic [NCOL-1:0]      plus;
  logic [NCOL-1:0]      moins;
  logic                 drop_ack;
  logic                 clear_ack;
  logic                 rej;
  logic                 busy;

  arbitre_piles #(.NCOL(NCOL), .HMAX(HMAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .drop_req  (drop_req),
    .drop_col  (drop_col),
    .clear_req (clear_req),
    .clear_col (clear_col),
    .hauteurs  (hauteurs),
    .plus      (plus),
    .moins     (moins),
    .drop_ack  (drop_ack),
    .clear_ack (clear_ack),
    .rej       (rej),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Column counters driven by the DUT pulses, with a bench-side load port
  logic [2:0] h        [NCOL];
  logic [2:0] load_val [NCOL];
  logic       load_en = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < NCOL; k++) begin
      if (load_en)                         h[k] <= load_val[k];
      else if (plus[k]  && h[k] != 3'd7)   h[k] <= h[k] + 3'd1;
      else if (moins[k] && h[k] != 3'd0)   h[k] <= h[k] - 3'd1;
    end
  end

  always_comb begin
    hauteurs = '0;
    for (int k = 0; k < NCOL; k++) hauteurs[3*k +: 3] = h[k];
  end

  // Expected outputs of the current cycle plus the scheduled future cycles
  typedef struct packed {
    logic [NCOL-1:0] pl;
    logic [NCOL-1:0] mo;
    logic            dack;
    logic            cack;
    logic            rj;
    logic            bz;
  } out_t;

  out_t cur;
  out_t sched[$];
  logic favour_drop;
  int   checks   = 0;
  int   failures = 0;
  int   cyc_n    = 0;

  function automatic out_t dut_out();
    out_t o;
    o.pl = plus; o.mo = moins; o.dack = drop_ack;
    o.cack = clear_ack; o.rj = rej; o.bz = busy;
    return o;
  endfunction

  // Advance the model across the coming clock edge using current inputs
  task automatic model_step();
    out_t          z;
    logic          win_clear;
    logic [CW-1:0] c;
    logic [2:0]    ht;
    logic          refused;
    z = '0;
    if (reset) begin
      sched.delete();
      favour_drop = 1'b0;
      cur = z;
    end else if (sched.size() > 0) begin
      cur = sched.pop_front();
    end else if (cur.bz) begin
      cur = z;
    end else if (drop_req || clear_req) begin
`ifdef ARB_RR_EN
      win_clear = clear_req && !(drop_req && favour_drop);
      if (drop_req && clear_req) favour_drop = win_clear;
`else
      win_clear = clear_req;
`endif
      c       = win_clear ? clear_col : drop_col;
      ht      = h[c];
      refused = win_clear ? (ht == 3'd0) : (int'(ht) >= HMAX);
      cur     = z;
      cur.bz  = 1'b1;
      if (refused) begin
        cur.rj   = 1'b1;
        cur.cack = win_clear;
        cur.dack = !win_clear;
      end else begin
        if (win_clear) cur.mo[c] = 1'b1;
        else           cur.pl[c] = 1'b1;
        z.bz = 1'b1;
        sched.push_back(z);
        z.cack = win_clear;
        z.dack = !win_clear;
        sched.push_back(z);
      end
    end else begin
      cur = z;
    end
  endtask

  task automatic compare();
    out_t a;
    a = dut_out();
    checks++;
    if (a !== cur) begin
      failures++;
      $display("FAIL outputs cycle %0d: actual plus=%b moins=%b dack=%b cack=%b rej=%b busy=%b required plus=%b moins=%b dack=%b cack=%b rej=%b busy=%b",
               cyc_n, a.pl, a.mo, a.dack, a.cack, a.rj, a.bz,
               cur.pl, cur.mo, cur.dack, cur.cack, cur.rj, cur.bz);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
    cyc_n++;
    compare();
  endtask

  task automatic set_h(input int col, input logic [2:0] v);
    for (int k = 0; k < NCOL; k++) load_val[k] = h[k];
    load_val[col] = v;
    load_en = 1'b1;
    cyc();
    load_en = 1'b0;
  endtask

  int         n;
  int         nclr;
  int         npl;
  int         gap;
  logic [7:0] seqv;

  initial begin
    reset = 1'b1; drop_req = 1'b0; clear_req = 1'b0;
    drop_col = '0; clear_col = '0;
    cur = '0; favour_drop = 1'b0;
    for (int k = 0; k < NCOL; k++) load_val[k] = 3'd3;
    load_en = 1'b1;
    cyc();
    cyc();
    load_en = 1'b0;
    chk("rst_outputs", {plus, moins, drop_ack, clear_ack, rej, busy}, 0);
    reset = 1'b0;
    cyc();

    // Accepted drop, column 2 at height 3
    set_h(2, 3'd3);
    drop_col = 2'd2; drop_req = 1'b1;
    cyc();
    chk("drop_issue_plus", plus, 4'b0100);
    chk("drop_issue_busy", busy, 1);
    cyc();
    chk("drop_gap_plus", plus, 0);
    chk("drop_gap_height", h[2], 4);
    cyc();
    chk("drop_ack", drop_ack, 1);
    chk("drop_ack_rej", rej, 0);
    drop_req = 1'b0;
    cyc();
    chk("drop_idle_busy", busy, 0);

    // Drop refused at full height
    set_h(1, 3'd7);
    drop_col = 2'd1; drop_req = 1'b1;
    cyc();
    chk("full_ack", drop_ack, 1);
    chk("full_rej", rej, 1);
    chk("full_plus", plus, 0);
    drop_req = 1'b0;
    cyc();
    chk("full_idle", busy, 0);
    chk("full_height", h[1], 7);

    // Clear refused on empty column
    set_h(0, 3'd0);
    clear_col = 2'd0; clear_req = 1'b1;
    cyc();
    chk("empty_ack", clear_ack, 1);
    chk("empty_rej", rej, 1);
    chk("empty_moins", moins, 0);
    clear_req = 1'b0;
    cyc();

    // Both requests on column 3 at height 2
    set_h(3, 3'd2);
    drop_col = 2'd3; clear_col = 2'd3;
    drop_req = 1'b1; clear_req = 1'b1;
    n = 0; nclr = 0; seqv = '0;
    for (int i = 0; i < 40 && (drop_req || clear_req); i++) begin
      cyc();
      if (clear_ack) begin
        seqv = {seqv[5:0], 1'b0, rej}; n++; nclr++;
`ifdef ARB_RR_EN
        clear_req = 1'b0;
`else
        if (nclr == 3) clear_req = 1'b0;
`endif
      end
      if (drop_ack) begin
        seqv = {seqv[5:0], 1'b1, rej}; n++;
        drop_req = 1'b0;
      end
    end
    chk("both_done", {drop_req, clear_req}, 0);
    drop_req = 1'b0; clear_req = 1'b0;
`ifdef ARB_RR_EN
    chk("both_nacks", n, 2);
    chk("both_order", seqv, 8'b0000_0010);
    chk("both_height", h[3], 2);
`else
    chk("both_nacks", n, 4);
    chk("both_order", seqv, 8'b0000_0110);
    chk("both_height", h[3], 1);
`endif
    cyc();

    // Reset during the GAP of a drop on column 1 (4 -> 5)
    set_h(1, 3'd4);
    drop_col = 2'd1; drop_req = 1'b1;
    cyc();
    chk("rgap_issue", plus, 4'b0010);
    cyc();
    chk("rgap_busy", busy, 1);
    reset = 1'b1; drop_req = 1'b0;
    cyc();
    chk("rgap_outputs", {plus, moins, drop_ack, clear_ack, rej, busy}, 0);
    chk("rgap_height", h[1], 5);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rgap_noack", drop_ack, 0);
    end

    // Back-to-back drops on column 3 from height 5
    set_h(3, 3'd5);
    drop_col = 2'd3; drop_req = 1'b1;
    n = 0; npl = 0; gap = 0; seqv = '0;
    for (int i = 0; i < 30 && drop_req; i++) begin
      cyc();
      if (plus[3]) begin
        if (npl > 0) chk("b2b_gap", gap >= 3, 1);
        npl++; gap = 0;
      end else begin
        gap++;
      end
      if (drop_ack) begin
        seqv = {seqv[6:0], rej}; n++;
        if (n == 3) drop_req = 1'b0;
      end
    end
    drop_req = 1'b0;
    chk("b2b_nacks", n, 3);
    chk("b2b_rej_seq", seqv[2:0], 3'b001);
    chk("b2b_npulses", npl, 2);
    chk("b2b_height", h[3], 7);
    cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 249) == 0);
      if (cur.dack && $urandom_range(0, 3) != 0) drop_req = 1'b0;
      else if (!drop_req && $urandom_range(0, 2) == 0) begin
        drop_req = 1'b1;
        drop_col = CW'($urandom_range(0, NCOL-1));
      end
      if (cur.cack && $urandom_range(0, 3) != 0) clear_req = 1'b0;
      else if (!clear_req && $urandom_range(0, 2) == 0) begin
        clear_req = 1'b1;
        clear_col = CW'($urandom_range(0, NCOL-1));
      end
      if ($urandom_range(0, 9) == 0) drop_col  = CW'($urandom_range(0, NCOL-1));
      if ($urandom_range(0, 9) == 0) clear_col = CW'($urandom_range(0, NCOL-1));
      load_en = ($urandom_range(0, 39) == 0);
      if (load_en) begin
        for (int k = 0; k < NCOL; k++) load_val[k] = 3'($urandom_range(0, 7));
      end
      cyc();
    end
    load_en = 1'b0; reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
